// File: rtl/enigma_sink.sv
// enigma_sink: receiving end of the ENIGMA port-C channel.
// Accepts {payload, id, qos} requests and tracks in-flight ids in a busy
// scoreboard. Each request waits a qos-dependent service latency in an
// in-order queue, is offered on the out_* handshake, and then its id is
// returned to the buffer on release_c/releaseid_c.
module enigma_sink #(
  parameter int DEPTH    = 4,
  parameter int LAT_BASE = 2,
  parameter int LAT_STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_c,
  input  logic [127:0] payload_c,
  input  logic [5:0]   id_c,
  input  logic [1:0]   qos_c,
  output logic         ready_c,
  output logic         conflict_c,
  output logic         release_c,
  output logic [5:0]   releaseid_c,
  output logic         out_valid,
  output logic [127:0] out_payload,
  output logic [5:0]   out_id,
  output logic [1:0]   out_qos,
  input  logic         out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

  // Service latency for a given qos, saturated to the 8-bit timer range.
  function automatic logic [7:0] lat(input logic [1:0] q);
    int l;
    l = LAT_BASE + (3 - int'(q)) * LAT_STEP;
    if (l > 255) return 8'd255;
    if (l < 0)   return 8'd0;
    return l[7:0];
  endfunction

  logic [127:0]  pay_mem [DEPTH];
  logic [5:0]    id_mem  [DEPTH];
  logic [1:0]    qos_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [63:0]   busy;
  logic [7:0]    timer, timer_nxt;
  state_t        state;

  logic          full, push, pop, load, head_from_in, head_ready_nxt;
  logic [127:0]  head_pay;
  logic [5:0]    head_id;
  logic [1:0]    head_qos;

  // The busy bit is read as registered; a release in this cycle is only
  // visible to the accept logic from the next cycle on.
  assign full       = (count == CW'(DEPTH));
  assign ready_c    = !full && !busy[id_c];
  assign conflict_c = valid_c && busy[id_c];
  assign push       = valid_c && ready_c;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (state == S_READY);

  // Next queue occupancy, next head entry and next head timer value.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    count_nxt = count;
    if (push && !pop) count_nxt = count + CW'(1);
    if (pop && !push) count_nxt = count - CW'(1);

    rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

    // The next head comes straight from the input when the queue is empty,
    // or when the only entry leaves while a new one arrives.
    head_from_in = (count == '0) || (pop && count == CW'(1));
    head_pay = head_from_in ? payload_c : pay_mem[rd_ptr_nxt];
    head_id  = head_from_in ? id_c      : id_mem[rd_ptr_nxt];
    head_qos = head_from_in ? qos_c     : qos_mem[rd_ptr_nxt];

    // A new head appears on a push into an empty queue or a pop that
    // leaves at least one entry behind.
    load = (count_nxt != '0) && ((count == '0) || pop);

    timer_nxt = timer;
    if (load)              timer_nxt = lat(head_qos);
    else if (timer != '0)  timer_nxt = timer - 8'd1;

    head_ready_nxt = (count_nxt != '0) && (timer_nxt == '0);
  end

  // Queue storage write port.
  // NOTE: storage is not reset; an entry is only ever read after being
  // written, and count/pointers (which are reset) decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pay_mem[wr_ptr] <= payload_c;
      id_mem[wr_ptr]  <= id_c;
      qos_mem[wr_ptr] <= qos_c;
    end
  end

  // Queue pointers, occupancy and per-id busy scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // A popped id can never equal a pushed id in the same cycle, because
      // the popped id is still busy and blocks acceptance.
      if (pop)  busy[out_id] <= 1'b0;
      if (push) busy[id_c]   <= 1'b1;
    end
  end

  // Head-slot state machine with its timer and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      timer       <= '0;
      out_payload <= '0;
      out_id      <= '0;
      out_qos     <= '0;
    end else begin
      timer <= timer_nxt;
      case (state)
        S_EMPTY: if (push)           state <= head_ready_nxt ? S_READY : S_WAIT;
        S_WAIT:  if (head_ready_nxt) state <= S_READY;
        S_READY: begin
          if (pop) begin
            if (count_nxt == '0)     state <= S_EMPTY;
            else if (head_ready_nxt) state <= S_READY;
            else                     state <= S_WAIT;
          end
        end
        default: state <= S_EMPTY;
      endcase
      // Output fields follow the head only while it is presented; otherwise
      // they keep their last values.
      if (head_ready_nxt) begin
        out_payload <= head_pay;
        out_id      <= head_id;
        out_qos     <= head_qos;
      end
    end
  end

  // One-cycle id return pulse after each downstream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      release_c   <= 1'b0;
      releaseid_c <= '0;
    end else begin
      release_c <= pop;
      if (pop) releaseid_c <= out_id;
    end
  end

endmodule

// File: tb/tb_enigma_sink.sv
// Self-checking bench for enigma_sink: a negedge scoreboard checks every
// handshake, accept decision and release pulse; directed sequences check
// latencies, conflicts, full queue, backpressure and asynchronous reset.
module tb_enigma_sink;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_c;
  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         out_valid;
  logic [127:0] out_payload;
  logic [5:0]   out_id;
  logic [1:0]   out_qos;
  logic         out_ready;

  enigma_sink #(.DEPTH(DEPTH), .LAT_BASE(2), .LAT_STEP(2)) dut (
    .clk(clk), .rst(rst),
    .valid_c(valid_c), .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c),
    .ready_c(ready_c), .conflict_c(conflict_c),
    .release_c(release_c), .releaseid_c(releaseid_c),
    .out_valid(out_valid), .out_payload(out_payload), .out_id(out_id),
    .out_qos(out_qos), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] payload;
    logic [5:0]   id;
    logic [1:0]   qos;
  } req_t;

  typedef struct {
    logic       valid;
    logic [5:0] id;
    logic       exp_ready;
    logic       exp_conflict;
  } probe_t;

  int checks = 0;
  int errors = 0;

  req_t       sb[$];
  logic [63:0] m_busy;
  logic       rel_exp;
  logic [5:0] rel_id_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected entries are queued at accept and compared at pop.
  always @(negedge clk) begin
    logic er;
    req_t h;
    if (rst) begin
      sb.delete();
      m_busy     = '0;
      rel_exp    = 1'b0;
      rel_id_exp = '0;
    end else begin
      check("mon_release", release_c, rel_exp);
      check("mon_releaseid", releaseid_c, rel_id_exp);
      er = (sb.size() < DEPTH) && !m_busy[id_c];
      check("mon_ready", ready_c, er);
      check("mon_conflict", conflict_c, valid_c && m_busy[id_c]);
      rel_exp = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_pop: got pop of id %0h expected no pending entry", out_id);
        end else begin
          h = sb.pop_front();
          check("mon_out_id", out_id, h.id);
          check("mon_out_payload", out_payload, h.payload);
          check("mon_out_qos", out_qos, h.qos);
          m_busy[h.id] = 1'b0;
          rel_exp      = 1'b1;
          rel_id_exp   = h.id;
        end
      end
      if (valid_c && er) begin
        sb.push_back('{payload_c, id_c, qos_c});
        m_busy[id_c] = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] id, input logic [1:0] q,
                       input logic [127:0] p);
    valid_c   = v;
    id_c      = id;
    qos_c     = q;
    payload_c = p;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain_out_valid", out_valid, 1'b0);
    check("drain_done", n < 200, 1'b1);
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    probe_t probes [6];
    int n;

    probes[0] = '{1'b1, 6'd20, 1'b0, 1'b1};
    probes[1] = '{1'b0, 6'd20, 1'b0, 1'b0};
    probes[2] = '{1'b1, 6'd21, 1'b1, 1'b0};
    probes[3] = '{1'b0, 6'd21, 1'b1, 1'b0};
    probes[4] = '{1'b1, 6'd0,  1'b1, 1'b0};
    probes[5] = '{1'b1, 6'd63, 1'b1, 1'b0};

    // Reset values.
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 6'd5, 2'd3, 128'h0);
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_id", out_id, 6'd0);
    check("rst_out_qos", out_qos, 2'd0);
    check("rst_out_payload", out_payload, 128'h0);
    check("rst_release", release_c, 1'b0);
    check("rst_releaseid", releaseid_c, 6'd0);
    check("rst_ready", ready_c, 1'b1);
    check("rst_conflict", conflict_c, 1'b0);
    drive(1'b0, 6'd0, 2'd0, 128'h0);
    step();
    rst = 1'b0;

    // Single qos3 request: out_valid two edges after accept.
    out_ready = 1'b1;
    drive(1'b1, 6'd5, 2'd3, 128'h1);
    step();                                  // accept edge E
    drive(1'b0, 6'd5, 2'd0, 128'h0);
    step();
    check("t1_not_yet", out_valid, 1'b0);
    step();                                  // E+2
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_id", out_id, 6'd5);
    check("t1_out_payload", out_payload, 128'h1);
    step();                                  // handshake edge
    check("t1_release", release_c, 1'b1);
    check("t1_releaseid", releaseid_c, 6'd5);
    check("t1_popped", out_valid, 1'b0);
    step();
    check("t1_release_end", release_c, 1'b0);
    check("t1_releaseid_hold", releaseid_c, 6'd5);
    drive(1'b1, 6'd5, 2'd3, 128'h0);
    #1;
    check("t1_busy_cleared", ready_c, 1'b1);
    valid_c = 1'b0;

    // Qos latencies: qos0 -> 8 edges, then qos2 -> 4 edges after pop.
    out_ready = 1'b0;
    step();
    drive(1'b1, 6'd1, 2'd0, 128'hA1);
    step();                                  // accept of id 1
    drive(1'b1, 6'd2, 2'd2, 128'hA2);
    step();
    drive(1'b0, 6'd0, 2'd0, 128'h0);
    wait_valid(30, n);
    check("t2_lat_q0", n + 1, 8);
    check("t2_head_id", out_id, 6'd1);
    check("t2_head_qos", out_qos, 2'd0);
    out_ready = 1'b1;
    step();                                  // pop edge of id 1
    check("t2_release", release_c, 1'b1);
    check("t2_releaseid", releaseid_c, 6'd1);
    check("t2_reload", out_valid, 1'b0);
    wait_valid(30, n);
    check("t2_lat_q2", n, 4);
    check("t2_head2_id", out_id, 6'd2);
    step();
    out_ready = 1'b0;
    step();

    // Same-id conflict with no same-cycle bypass.
    drive(1'b1, 6'd9, 2'd0, 128'h9A);
    step();
    drive(1'b1, 6'd9, 2'd3, 128'h9B);
    #1;
    check("t3_conflict", conflict_c, 1'b1);
    check("t3_blocked", ready_c, 1'b0);
    wait_valid(30, n);
    check("t3_head_ready", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("t3_no_bypass_conflict", conflict_c, 1'b1);
    check("t3_no_bypass_ready", ready_c, 1'b0);
    step();                                  // pop edge of first id 9
    check("t3_release", release_c, 1'b1);
    check("t3_releaseid", releaseid_c, 6'd9);
    check("t3_ready_after", ready_c, 1'b1);
    check("t3_conflict_after", conflict_c, 1'b0);
    step();                                  // accept of second id 9
    drive(1'b0, 6'd9, 2'd0, 128'h0);
    #1;
    check("t3_busy_again", ready_c, 1'b0);
    drain();

    // Full queue: ids 0..3 fill it, id 4 is refused even alongside a pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(i), 2'd3, 128'hF0 + 128'(i));
      step();
    end
    drive(1'b1, 6'd4, 2'd3, 128'hF4);
    #1;
    check("t4_full_ready", ready_c, 1'b0);
    check("t4_full_conflict", conflict_c, 1'b0);
    check("t4_head_ready", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("t4_full_with_pop", ready_c, 1'b0);
    step();                                  // pop of id 0
    out_ready = 1'b0;
    #1;
    check("t4_space", ready_c, 1'b1);
    step();                                  // accept of id 4
    drive(1'b0, 6'd0, 2'd0, 128'h0);
    drain();

    // Backpressure with a held head, plus accept/conflict probe table.
    drive(1'b1, 6'd20, 2'd3, 128'h20);
    step();
    drive(1'b0, 6'd0, 2'd0, 128'h0);
    wait_valid(10, n);
    check("t5_head_ready", out_valid, 1'b1);
    foreach (probes[k]) begin
      step();
      drive(probes[k].valid, probes[k].id, 2'd0, 128'h0);
      #1;
      check($sformatf("probe%0d_ready", k), ready_c, probes[k].exp_ready);
      check($sformatf("probe%0d_conflict", k), conflict_c, probes[k].exp_conflict);
      valid_c = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_id", out_id, 6'd20);
      check("t5_no_release", release_c, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check("t5_release", release_c, 1'b1);
    check("t5_releaseid", releaseid_c, 6'd20);
    out_ready = 1'b0;
    step();
    check("t5_single_pulse", release_c, 1'b0);
    check("t5_empty", out_valid, 1'b0);

    // Asynchronous reset with entries queued and a release pending.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(30 + i), 2'd3, 128'h300 + 128'(i));
      step();
    end
    drive(1'b0, 6'd31, 2'd0, 128'h0);
    wait_valid(10, n);
    out_ready = 1'b1;
    step();                                  // pop of id 30
    check("t6_release_pending", release_c, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_release", release_c, 1'b0);
    check("t6_rst_releaseid", releaseid_c, 6'd0);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_id", out_id, 6'd0);
    check("t6_rst_ready", ready_c, 1'b1);
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_release", release_c, 1'b0);
      check("t6_stays_empty", out_valid, 1'b0);
    end
    drive(1'b1, 6'd31, 2'd3, 128'h31B);
    #1;
    check("t6_reuse_id", ready_c, 1'b1);
    step();
    drive(1'b0, 6'd0, 2'd0, 128'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
